wbu_char_to_codeword: RTL

//  Receive path of the hex-bit debug bus: the counterpart of the codeword-to-character output chain.

---
 rtl/wbu_char_to_codeword.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/wbu_char_to_codeword.sv
// rtl/wbu_char_to_codeword.sv - decodes received printable bytes to hexbits and packs them into 36-bit codewords
module wbu_char_to_codeword #(
    parameter int TIMEOUT   = 1_000_000,
    parameter int LGTIMEOUT = 20
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_stb,
    input  logic [7:0]  i_byte,
    output logic        o_stb,
    output logic [35:0] o_codword,
    input  logic        i_busy,
    output logic        o_active,
    output logic        o_err
);

    typedef enum logic [1:0] {TOK_HEX, TOK_WS, TOK_BAD} tok_t;
    typedef enum logic {IDLE, COLLECT} state_t;

    localparam logic [LGTIMEOUT-1:0] TO_VAL = LGTIMEOUT'(TIMEOUT);

    tok_t                 dec_tok_c, dec_tok;
    logic [5:0]           dec_bits_c, dec_bits;
    logic                 dec_valid;

    state_t               state, state_nx;
    logic [35:0]          cw, cw_nx;
    logic [2:0]           rem, rem_nx;
    logic [2:0]           idx, idx_nx;
    logic [LGTIMEOUT-1:0] timer;
    logic                 timeout_hit;
    logic                 word_done;
    logic                 bad_tok;
    logic                 load;

    // Six-bit arithmetic on i_byte[5:0] is enough: each character range maps linearly mod 64
    always_comb begin
        dec_tok_c  = TOK_BAD;
        dec_bits_c = 6'd0;
        if (i_byte >= "0" && i_byte <= "9") begin
            dec_tok_c  = TOK_HEX;
            dec_bits_c = {2'b00, i_byte[3:0]};
        end else if (i_byte >= "A" && i_byte <= "Z") begin
            dec_tok_c  = TOK_HEX;
            dec_bits_c = i_byte[5:0] + 6'd9;
        end else if (i_byte >= "a" && i_byte <= "z") begin
            dec_tok_c  = TOK_HEX;
            dec_bits_c = i_byte[5:0] + 6'd3;
        end else if (i_byte == "@") begin
            dec_tok_c  = TOK_HEX;
            dec_bits_c = 6'd62;
        end else if (i_byte == "%") begin
            dec_tok_c  = TOK_HEX;
            dec_bits_c = 6'd63;
        end else if (i_byte == 8'h20 || i_byte == 8'h09 || i_byte == 8'h0A || i_byte == 8'h0D) begin
            dec_tok_c  = TOK_WS;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            dec_valid <= 1'b0;
            dec_tok   <= TOK_BAD;
            dec_bits  <= 6'd0;
        end else begin
            dec_valid <= i_stb;
            if (i_stb) begin
                dec_tok  <= dec_tok_c;
                dec_bits <= dec_bits_c;
            end
        end
    end

    // A pending byte (decoded or just arriving) always takes priority over expiry
    assign timeout_hit = (TIMEOUT != 0) && (state == COLLECT) && (timer == TO_VAL)
                         && !dec_valid && !i_stb;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (dec_valid) begin
            case (dec_tok)
                TOK_HEX: begin
                    if (state == IDLE) begin
                        state_nx = (dec_bits[5:4] == 2'b00) ? IDLE : COLLECT;
                    end else if (rem == 3'd1) begin
                        state_nx = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end else if (timeout_hit) begin
            state_nx = IDLE;
        end
    end

    always_comb begin
        word_done = 1'b0;
        bad_tok   = 1'b0;
        cw_nx     = cw;
        rem_nx    = rem;
        idx_nx    = idx;
        if (dec_valid) begin
            case (dec_tok)
                TOK_HEX: begin
                    if (state == IDLE) begin
                        cw_nx  = {dec_bits, 30'd0};
                        idx_nx = 3'd1;
                        case (dec_bits[5:4])
                            2'b00:   word_done = 1'b1;
                            2'b01:   rem_nx = 3'd1;
                            2'b10:   rem_nx = 3'd2;
                            default: rem_nx = 3'd5;
                        endcase
                    end else begin
                        case (idx)
                            3'd1:    cw_nx[29:24] = dec_bits;
                            3'd2:    cw_nx[23:18] = dec_bits;
                            3'd3:    cw_nx[17:12] = dec_bits;
                            3'd4:    cw_nx[11:6]  = dec_bits;
                            3'd5:    cw_nx[5:0]   = dec_bits;
                            default: cw_nx = cw;
                        endcase
                        rem_nx    = rem - 3'd1;
                        idx_nx    = idx + 3'd1;
                        word_done = (rem == 3'd1);
                    end
                end
                TOK_BAD: bad_tok = 1'b1;
                default: bad_tok = 1'b0;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cw    <= 36'd0;
            rem   <= 3'd0;
            idx   <= 3'd0;
            timer <= '0;
        end else begin
            cw  <= cw_nx;
            rem <= rem_nx;
            idx <= idx_nx;
            if (i_stb || state != COLLECT) begin
                timer <= '0;
            end else if (timer != TO_VAL) begin
                timer <= timer + LGTIMEOUT'(1);
            end
        end
    end

    assign load = word_done && (!o_stb || !i_busy);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_stb     <= 1'b0;
            o_codword <= 36'd0;
            o_err     <= 1'b0;
        end else begin
            if (load) begin
                o_stb     <= 1'b1;
                o_codword <= cw_nx;
            end else if (!i_busy) begin
                o_stb <= 1'b0;
            end
            o_err <= bad_tok || (word_done && o_stb && i_busy);
        end
    end

    assign o_active = (state == COLLECT) || dec_valid;

endmodule
